// File: rtl/sha256_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_seq_pkg
//  Purpose  : Shared types and constants for the sha256 message sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package sha256_seq_pkg;

    typedef enum logic [2:0] {
        FILL  = 3'd0,
        PAD   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } seq_state_e;

    localparam logic [31:0] PAD_WORD  = 32'h8000_0000;
    localparam int          BLK_WORDS = 16;

    // Byte count of a last word; anything above 4 means a full word.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_last_word_pad.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_last_word_pad
//  Purpose  : Masks the tail of the last message word and inserts the 0x80
//             marker byte; flags when the marker must go into the next word.
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_last_word_pad
    import sha256_seq_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_bytes,
    output logic [31:0] o_word,
    output logic        o_pad_pend
);

    logic [2:0] w_n;

    assign w_n = clamp_bytes(i_bytes);

    // Byte b = 0 is the earliest byte and sits in the top lane.
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign o_word[31-8*b -: 8] = (3'(b) < w_n)  ? i_data[31-8*b -: 8] :
                                     (3'(b) == w_n) ? PAD_WORD[31:24]      :
                                                      8'h00;
    end

    assign o_pad_pend = (w_n == 3'd4);

endmodule
`default_nettype wire

// File: rtl/sha256_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_msg_sequencer
//  Purpose  : Streams 32-bit message words, applies SHA-256 padding, packs
//             512-bit blocks, drives the core and returns the digest.
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_sequencer
    import sha256_seq_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         abort_i,
    input  logic         msg_valid_i,
    output logic         msg_ready_o,
    input  logic [31:0]  msg_data_i,
    input  logic         msg_last_i,
    input  logic [2:0]   msg_bytes_i,
    output logic         core_init_o,
    output logic         core_next_o,
    output logic [511:0] core_block_o,
    input  logic         core_ready_i,
    input  logic         core_digest_valid_i,
    input  logic [255:0] core_digest_i,
    output logic         dig_valid_o,
    input  logic         dig_ready_i,
    output logic [255:0] dig_o,
    output logic         busy_o,
    output logic         len_ovf_o
);

    localparam int c_len_zext = 61 - LEN_W;

    seq_state_e       r_state, w_state_nxt;
    logic [31:0]      r_buf [BLK_WORDS];
    logic [3:0]       r_word_idx;
    logic [LEN_W-1:0] r_byte_cnt;
    logic             r_first_blk, r_pad_pend, r_final, r_msg_done, r_wait_first, r_len_ovf;
    logic [255:0]     r_dig;

    logic [31:0]      w_pad_word;
    logic             w_pad_pend;
    logic [2:0]       w_add;
    logic [LEN_W:0]   w_cnt_sum;
    logic             w_new_msg, w_len_step, w_wait_done;
    logic [63:0]      w_len_bits;

    sha256_last_word_pad u_last_pad (
        .i_data     (msg_data_i),
        .i_bytes    (msg_bytes_i),
        .o_word     (w_pad_word),
        .o_pad_pend (w_pad_pend)
    );

    assign w_add       = msg_last_i ? clamp_bytes(msg_bytes_i) : 3'd4;
    assign w_cnt_sum   = {1'b0, r_byte_cnt} + {{(LEN_W-2){1'b0}}, w_add};
    assign w_new_msg   = r_first_blk && (r_word_idx == 4'd0);
    assign w_len_bits  = {{c_len_zext{1'b0}}, r_byte_cnt, 3'b000};
    assign w_len_step  = (r_state == PAD) && (r_word_idx == 4'd14) && !r_pad_pend;
    // The core may still show ready/valid from the previous op in the cycle after the pulse.
    assign w_wait_done = (r_state == WAIT) && !r_wait_first && core_ready_i &&
                         (!r_final || core_digest_valid_i);

    for (genvar k = 0; k < BLK_WORDS; k++) begin : g_blk
        assign core_block_o[511-32*k -: 32] = r_buf[k];
    end

    assign dig_o     = r_dig;
    assign busy_o    = (r_state != FILL);
    assign len_ovf_o = r_len_ovf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= FILL;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        msg_ready_o = 1'b0;
        core_init_o = 1'b0;
        core_next_o = 1'b0;
        dig_valid_o = 1'b0;
        case (r_state)
            FILL: begin
                msg_ready_o = 1'b1;
                if (msg_valid_i) begin
                    if (r_word_idx == 4'd15) w_state_nxt = ISSUE;
                    else if (msg_last_i)     w_state_nxt = PAD;
                end
            end
            PAD: begin
                if (w_len_step || (r_word_idx == 4'd15)) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (core_ready_i && !abort_i) begin
                    core_init_o = r_first_blk;
                    core_next_o = !r_first_blk;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_wait_done) begin
                    if (r_final)         w_state_nxt = OUT;
                    else if (r_msg_done) w_state_nxt = PAD;
                    else                 w_state_nxt = FILL;
                end
            end
            OUT: begin
                dig_valid_o = 1'b1;
                if (dig_ready_i) w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
        if (abort_i) w_state_nxt = FILL;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < BLK_WORDS; k++) r_buf[k] <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_first_blk  <= 1'b1;
            r_pad_pend   <= 1'b0;
            r_final      <= 1'b0;
            r_msg_done   <= 1'b0;
            r_wait_first <= 1'b0;
            r_len_ovf    <= 1'b0;
            r_dig        <= '0;
        end else if (abort_i) begin
            for (int k = 0; k < BLK_WORDS; k++) r_buf[k] <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_first_blk  <= 1'b1;
            r_pad_pend   <= 1'b0;
            r_final      <= 1'b0;
            r_msg_done   <= 1'b0;
            r_wait_first <= 1'b0;
            r_len_ovf    <= 1'b0;
            r_dig        <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (msg_valid_i) begin
                        r_buf[r_word_idx] <= msg_last_i ? w_pad_word : msg_data_i;
                        r_word_idx        <= r_word_idx + 4'd1;
                        r_byte_cnt        <= w_cnt_sum[LEN_W-1:0];
                        r_len_ovf         <= w_new_msg ? w_cnt_sum[LEN_W]
                                                       : (r_len_ovf | w_cnt_sum[LEN_W]);
                        if (msg_last_i) begin
                            r_msg_done <= 1'b1;
                            r_pad_pend <= w_pad_pend;
                        end
                    end
                end
                PAD: begin
                    if (w_len_step) begin
                        r_buf[14] <= w_len_bits[63:32];
                        r_buf[15] <= w_len_bits[31:0];
                        r_final   <= 1'b1;
                    end else begin
                        r_buf[r_word_idx] <= r_pad_pend ? PAD_WORD : 32'h0;
                        r_pad_pend        <= 1'b0;
                        r_word_idx        <= r_word_idx + 4'd1;
                    end
                end
                ISSUE: begin
                    if (core_ready_i) begin
                        r_first_blk  <= 1'b0;
                        r_wait_first <= 1'b1;
                    end
                end
                WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_wait_done) begin
                        r_word_idx <= '0;
                        if (r_final) r_dig <= core_digest_i;
                    end
                end
                OUT: begin
                    if (dig_ready_i) begin
                        r_word_idx  <= '0;
                        r_byte_cnt  <= '0;
                        r_pad_pend  <= 1'b0;
                        r_final     <= 1'b0;
                        r_msg_done  <= 1'b0;
                        r_first_blk <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_msg_sequencer
//  Purpose  : Self-checking bench with a behavioural SHA-256 core and a
//             byte-level padding reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_sequencer;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         rst_n, abort, msg_valid, msg_last, dig_ready;
    logic [31:0]  msg_data;
    logic [2:0]   msg_bytes;
    logic         msg_ready_o, core_init_o, core_next_o, dig_valid_o, busy_o, len_ovf_o;
    logic [511:0] core_block_o;
    logic         core_ready, core_dv;
    logic [255:0] core_digest, dig_o, core_h;

    int           n_vec = 0, n_err = 0, cyc = 0, npulse = 0, last_acc_cyc = 0;
    byte unsigned m_bytes[$];
    logic [511:0] blk_q[$], exp_blk[$];
    bit           init_q[$];
    int           pulse_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_msg_sequencer #(.LEN_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .abort_i(abort),
        .msg_valid_i(msg_valid), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data),
        .msg_last_i(msg_last), .msg_bytes_i(msg_bytes),
        .core_init_o(core_init_o), .core_next_o(core_next_o), .core_block_o(core_block_o),
        .core_ready_i(core_ready), .core_digest_valid_i(core_dv), .core_digest_i(core_digest),
        .dig_valid_o(dig_valid_o), .dig_ready_i(dig_ready), .dig_o(dig_o),
        .busy_o(busy_o), .len_ovf_o(len_ovf_o));

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    function automatic void load_str(input string s);
        m_bytes.delete();
        for (int i = 0; i < s.len(); i++) m_bytes.push_back(s[i]);
    endfunction

    function automatic void load_rand(input int len);
        m_bytes.delete();
        for (int i = 0; i < len; i++) m_bytes.push_back(8'($urandom));
    endfunction

    // Reference padding: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic build_expected();
        byte unsigned    pb[$];
        logic [511:0]    blk;
        longint unsigned bits;
        pb   = m_bytes;
        bits = longint'(m_bytes.size()) * 8;
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pb.push_back(8'(bits >> (8 * i)));
        exp_blk.delete();
        for (int k = 0; k < pb.size() / 64; k++) begin
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pb[64*k+i];
            exp_blk.push_back(blk);
        end
    endtask

    // Behavioural core: keeps ready/valid high one cycle past the pulse, then computes.
    initial begin
        core_ready = 1'b1; core_dv = 1'b0; core_digest = '0; core_h = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (core_init_o || core_next_o)) begin
                blk_q.push_back(core_block_o);
                init_q.push_back(core_init_o);
                pulse_cyc_q.push_back(cyc);
                npulse++;
                core_h = sha_compress(core_init_o ? IV : core_h, core_block_o);
                @(posedge clk); @(posedge clk); #1;
                core_ready = 1'b0; core_dv = 1'b0;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
                core_digest = core_h; core_ready = 1'b1; core_dv = 1'b1;
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
        int guard = 0;
        bit done  = 0;
        msg_valid = 1'b1; msg_data = d; msg_last = last; msg_bytes = nb;
        while (!done) begin
            @(negedge clk);
            if (msg_ready_o === 1'b1) done = 1;
            else if (++guard > 3000) begin
                n_vec++; n_err++;
                $display("FAIL send_word timeout: msg_ready_o=%b required=1", msg_ready_o);
                done = 1;
            end
        end
        last_acc_cyc = cyc;
        @(posedge clk); #1;
        msg_valid = 1'b0; msg_last = 1'b0; msg_data = $urandom; msg_bytes = 3'($urandom);
    endtask

    task automatic send_msg(input bit extra_zero);
        int L, nw, nl, idx;
        logic [31:0] d;
        L = m_bytes.size();
        if (L == 0)                            begin nw = 1;         nl = 0; end
        else if (extra_zero && (L % 4 == 0))   begin nw = L / 4 + 1; nl = 0; end
        else                                   begin nw = (L + 3) / 4; nl = L - 4 * (nw - 1); end
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                idx = 4 * w + b;
                d[31-8*b -: 8] = (idx < L) ? m_bytes[idx] : 8'($urandom);
            end
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if (w == nw - 1) send_word(d, 1'b1, (nl == 4) ? 3'($urandom_range(4, 7)) : 3'(nl));
            else             send_word(d, 1'b0, 3'($urandom));
        end
    endtask

    task automatic run_and_check(input string name, input bit extra_zero, input bit chk_const,
                                 input logic [255:0] const_dig, input int hold);
        logic [255:0] model_dig, d0;
        int guard = 0;
        blk_q.delete(); init_q.delete(); pulse_cyc_q.delete();
        build_expected();
        model_dig = IV;
        foreach (exp_blk[k]) model_dig = sha_compress(model_dig, exp_blk[k]);
        send_msg(extra_zero);
        do begin @(negedge clk); guard++; end while (dig_valid_o !== 1'b1 && guard < 5000);
        n_vec++;
        if (dig_valid_o !== 1'b1) begin
            n_err++; $display("FAIL %s dig_valid timeout: got %b required 1", name, dig_valid_o);
        end
        n_vec++;
        if (blk_q.size() != exp_blk.size()) begin
            n_err++; $display("FAIL %s block count: got %0d required %0d", name, blk_q.size(), exp_blk.size());
        end else begin
            foreach (exp_blk[k]) begin
                n_vec++;
                if (blk_q[k] !== exp_blk[k]) begin
                    n_err++; $display("FAIL %s block %0d: got %h required %h", name, k, blk_q[k], exp_blk[k]);
                end
                n_vec++;
                if (init_q[k] !== (k == 0)) begin
                    n_err++; $display("FAIL %s pulse kind %0d: init got %b required %b", name, k, init_q[k], k == 0);
                end
            end
        end
        n_vec++;
        if (dig_o !== model_dig) begin
            n_err++; $display("FAIL %s digest: got %h required %h", name, dig_o, model_dig);
        end
        if (chk_const) begin
            n_vec++;
            if (dig_o !== const_dig) begin
                n_err++; $display("FAIL %s known digest: got %h required %h", name, dig_o, const_dig);
            end
        end
        d0 = dig_o;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            n_vec++;
            if (dig_valid_o !== 1'b1 || dig_o !== d0 || msg_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL %s hold cycle %0d: valid=%b ready=%b busy=%b dig=%h required valid=1 ready=0 busy=1 dig=%h",
                         name, c, dig_valid_o, msg_ready_o, busy_o, dig_o, d0);
            end
        end
        dig_ready = 1'b1;
        @(posedge clk); #1;
        dig_ready = 1'b0;
        n_vec++;
        if (dig_valid_o !== 1'b0 || msg_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s after handshake: valid=%b ready=%b busy=%b required 0 1 0", name, dig_valid_o, msg_ready_o, busy_o);
        end
        n_vec++;
        if (len_ovf_o !== 1'b0) begin
            n_err++; $display("FAIL %s len_ovf: got %b required 0", name, len_ovf_o);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_vec++;
        if (msg_ready_o !== 1'b1 || busy_o !== 1'b0 || core_init_o !== 1'b0 || core_next_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s control: ready=%b busy=%b init=%b next=%b required 1 0 0 0",
                     name, msg_ready_o, busy_o, core_init_o, core_next_o);
        end
        n_vec++;
        if (dig_valid_o !== 1'b0 || dig_o !== '0 || len_ovf_o !== 1'b0) begin
            n_err++; $display("FAIL %s digest port: valid=%b ovf=%b dig=%h required 0 0 0", name, dig_valid_o, len_ovf_o, dig_o);
        end
        n_vec++;
        if (core_block_o !== '0) begin
            n_err++; $display("FAIL %s block buffer: got %h required 0", name, core_block_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_held");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset_released");
    endtask

    task automatic test_abc();
        load_str("abc");
        run_and_check("abc", 1'b0, 1'b1,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0);
        n_vec++;
        if (pulse_cyc_q.size() < 1 || pulse_cyc_q[0] != last_acc_cyc + 15) begin
            n_err++;
            $display("FAIL abc latency: pulse at %0d required %0d",
                     (pulse_cyc_q.size() > 0) ? pulse_cyc_q[0] : -1, last_acc_cyc + 15);
        end
    endtask

    task automatic test_empty();
        m_bytes.delete();
        run_and_check("empty", 1'b0, 1'b1,
            256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 0);
    endtask

    task automatic test_two_block_56();
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        run_and_check("msg56", 1'b0, 1'b1,
            256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 0);
    endtask

    task automatic test_64_bytes();
        logic [511:0] b2;
        load_rand(64);
        run_and_check("msg64", 1'b0, 1'b0, '0, 0);
        n_vec++;
        if (blk_q.size() < 2) begin
            n_err++; $display("FAIL msg64 second block missing: got %0d blocks required 2", blk_q.size());
        end else begin
            b2 = blk_q[1];
            if (b2[511:480] !== 32'h8000_0000 || b2[31:0] !== 32'h0000_0200) begin
                n_err++;
                $display("FAIL msg64 block2 words: word0=%h word15=%h required 80000000 00000200", b2[511:480], b2[31:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        load_rand(20);
        run_and_check("backpressure", 1'b0, 1'b0, '0, 20);
    endtask

    task automatic test_abort();
        int np0, guard;
        load_rand(150);
        np0 = npulse;
        for (int w = 0; w < 16; w++)
            send_word({m_bytes[4*w], m_bytes[4*w+1], m_bytes[4*w+2], m_bytes[4*w+3]}, 1'b0, 3'd4);
        guard = 0;
        do begin @(negedge clk); guard++; end while (npulse == np0 && guard < 200);
        @(posedge clk); #1;
        n_vec++;
        if (npulse == np0 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL abort setup: pulses=%0d busy=%b required >%0d and 1", npulse, busy_o, np0);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outputs("after_abort");
        load_str("abc");
        run_and_check("abc_after_abort", 1'b0, 1'b1,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0);
    endtask

    task automatic test_async_reset();
        send_word(32'h6162_6300, 1'b1, 3'd3);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (busy_o !== 1'b1) begin
            n_err++; $display("FAIL async_reset setup: busy=%b required 1", busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        load_rand(33);
        run_and_check("after_reset", 1'b0, 1'b0, '0, 0);
    endtask

    task automatic test_random();
        int lens [19] = '{0, 1, 3, 4, 52, 53, 55, 56, 57, 59, 60, 61, 63, 64, 65, 119, 120, 124, 128};
        foreach (lens[i]) begin
            load_rand(lens[i]);
            run_and_check($sformatf("len%0d", lens[i]), 1'($urandom_range(0, 1)), 1'b0, '0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            load_rand($urandom_range(0, 200));
            run_and_check($sformatf("rand%0d_len%0d", i, m_bytes.size()), 1'($urandom_range(0, 1)), 1'b0, '0, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; abort = 1'b0; msg_valid = 1'b0; msg_last = 1'b0;
        msg_data = '0; msg_bytes = '0; dig_ready = 1'b0;
        test_reset();
        test_abc();
        test_empty();
        test_two_block_56();
        test_64_bytes();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
